// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch redirect and data-memory wait stall.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module riscv_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_idx,
  input  logic [4:0]  id_rs2_idx,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_memtoreg,
  input  logic [4:0]  ex_rd_idx,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        mem_wb_flush,
  output logic        pc_redirect,
  output logic        mem_timeout,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

  state_t     state, state_nxt;
  logic       load_use;
  logic       mem_wait;
  logic [7:0] wait_cnt, wait_cnt_nxt;

  assign mem_wait = mem_req & ~mem_ack;
  assign load_use = ex_memtoreg && (ex_rd_idx != 5'd0) &&
                    ((id_use_rs1 && (ex_rd_idx == id_rs1_idx)) ||
                     (id_use_rs2 && (ex_rd_idx == id_rs2_idx)));

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    pc_redirect  = 1'b0;
    state_nxt    = state;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
            state_nxt    = MEM_WAIT;
          end else if (ex_branch_taken) begin
            pc_redirect  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            state_nxt    = REDIRECT;
          end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
          end
        end
        MEM_WAIT: begin
          // EX is frozen here, so a pending branch is deferred until release
          if (!mem_ack) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
          end else begin
            state_nxt    = RUN;
          end
        end
        REDIRECT: begin
          if_id_flush = 1'b1;
          state_nxt   = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (state == RUN)
      wait_cnt_nxt = '0;
    else if (state == MEM_WAIT && !mem_ack && wait_cnt != '1)
      wait_cnt_nxt = wait_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= mem_timeout | (wait_cnt_nxt == '1);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (id_ex_flush | if_id_flush)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Self-checking bench for riscv_hazard_ctrl: directed scenarios followed by random traffic,
// all compared against a behavioural model of the hazard rules.
module tb_riscv_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic        id_use_rs1, id_use_rs2, ex_memtoreg, ex_branch_taken, mem_req, mem_ack;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, mem_wb_flush, pc_redirect, mem_timeout;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  riscv_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memtoreg(ex_memtoreg), .ex_rd_idx(ex_rd_idx),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
    .pc_redirect(pc_redirect), .mem_timeout(mem_timeout),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  // id_ex_flush, ex_mem_stall, mem_wb_flush, pc_redirect
  localparam logic [7:0] P_NONE = 8'b0000_0000;
  localparam logic [7:0] P_MEM  = 8'b1101_0110;
  localparam logic [7:0] P_RED  = 8'b0010_1001;
  localparam logic [7:0] P_BUB  = 8'b0010_0000;
  localparam logic [7:0] P_LU   = 8'b1100_1000;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Behavioural model: memory hold pending, one bubble pending, current wait episode length
  bit          m_held = 1'b0;
  bit          m_bubble = 1'b0;
  int          m_episode = 0;
  bit          m_timeout = 1'b0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_flushes = '0;

  task automatic idle();
    id_rs1_idx = '0; id_rs2_idx = '0; ex_rd_idx = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memtoreg = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic step(input string tag);
    logic [7:0]  e, obs;
    logic [31:0] e_sc, e_fc;
    bit          mw, lu;
    @(negedge clk);
    mw = mem_req && !mem_ack;
    lu = ex_memtoreg && (ex_rd_idx != 0) &&
         ((id_use_rs1 && ex_rd_idx == id_rs1_idx) || (id_use_rs2 && ex_rd_idx == id_rs2_idx));
    if (rst)                  e = P_NONE;
    else if (m_held)          e = mem_ack ? P_NONE : P_MEM;
    else if (m_bubble)        e = P_BUB;
    else if (mw)              e = P_MEM;
    else if (ex_branch_taken) e = P_RED;
    else if (lu)              e = P_LU;
    else                      e = P_NONE;
    obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_stall, mem_wb_flush, pc_redirect};
`ifdef HAZARD_PERF_CNT_EN
    e_sc = m_stalls;
    e_fc = m_flushes;
`else
    e_sc = '0;
    e_fc = '0;
`endif
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s outputs: observed %b expected %b", tag, obs, e);
    end
    vectors++;
    assert (mem_timeout === m_timeout) else begin
      miscompares++;
      $error("FAIL %s mem_timeout: observed %b expected %b", tag, mem_timeout, m_timeout);
    end
    vectors++;
    assert (perf_stall_cnt === e_sc) else begin
      miscompares++;
      $error("FAIL %s perf_stall_cnt: observed %0d expected %0d", tag, perf_stall_cnt, e_sc);
    end
    vectors++;
    assert (perf_flush_cnt === e_fc) else begin
      miscompares++;
      $error("FAIL %s perf_flush_cnt: observed %0d expected %0d", tag, perf_flush_cnt, e_fc);
    end
    @(posedge clk);
    if (rst) begin
      m_held = 1'b0; m_bubble = 1'b0; m_episode = 0; m_timeout = 1'b0;
      m_stalls = '0; m_flushes = '0;
    end else begin
      if (m_held) begin
        if (!mem_ack) m_episode++;
        m_held = !mem_ack;
      end else if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (mw) begin
        m_held = 1'b1;
        m_episode = 0;
      end else if (ex_branch_taken) begin
        m_bubble = 1'b1;
      end
      if (m_episode >= 255) m_timeout = 1'b1;
      if (e[7]) m_stalls = m_stalls + 1;
      if (e[5] || e[3]) m_flushes = m_flushes + 1;
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    step("reset_busy_inputs");
    idle();
    step("reset_idle");
    rst = 1'b0;
    step("run_idle");

    // Load-use on rs2, then released, then r0 never interlocks, then rs1
    ex_memtoreg = 1'b1; ex_rd_idx = 5'd5; id_rs2_idx = 5'd5; id_use_rs2 = 1'b1;
    step("load_use_rs2");
    idle();
    step("load_use_release");
    ex_memtoreg = 1'b1; ex_rd_idx = 5'd0; id_rs2_idx = 5'd0; id_use_rs2 = 1'b1;
    step("load_use_r0");
    idle();
    ex_memtoreg = 1'b1; ex_rd_idx = 5'd9; id_rs1_idx = 5'd9; id_use_rs1 = 1'b1;
    step("load_use_rs1");
    id_use_rs1 = 1'b0;
    step("load_use_unused_src");
    idle();

    // Branch: redirect, one bubble (second branch ignored), then quiet
    ex_branch_taken = 1'b1;
    step("branch_c0");
    step("branch_c1_ignored");
    ex_branch_taken = 1'b0;
    step("branch_c2");
    step("branch_c3");

    // Memory wait: three stall cycles, release on ack
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) step("mem_wait");
    mem_ack = 1'b1;
    step("mem_ack");
    idle();
    step("mem_after");

    // Everything at once: memory wins, branch deferred until after ack
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    ex_memtoreg = 1'b1; ex_rd_idx = 5'd3; id_rs1_idx = 5'd3; id_use_rs1 = 1'b1;
    step("simul_c0");
    step("simul_c1");
    mem_ack = 1'b1;
    step("simul_ack");
    mem_req = 1'b0; mem_ack = 1'b0;
    step("simul_redirect");
    idle();
    step("simul_bubble");
    step("simul_quiet");

    // Watchdog: long wait sets sticky timeout; ack still releases
    mem_req = 1'b1;
    for (int i = 0; i < 300; i++) step("watchdog");
    vectors++;
    assert (mem_timeout === 1'b1) else begin
      miscompares++;
      $error("FAIL watchdog_set: observed %b expected 1", mem_timeout);
    end
    mem_ack = 1'b1;
    step("watchdog_ack");
    idle();
    step("timeout_sticky");
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step("rewait");
    rst = 1'b1;
    step("reset_mid_wait");
    rst = 1'b0;
    idle();
    step("after_reset_wait");
    vectors++;
    assert (mem_timeout === 1'b0) else begin
      miscompares++;
      $error("FAIL timeout_cleared: observed %b expected 0", mem_timeout);
    end

    // Reset in REDIRECT leaves no bubble behind
    ex_branch_taken = 1'b1;
    step("pre_reset_branch");
    ex_branch_taken = 1'b0;
    rst = 1'b1;
    step("reset_mid_redirect");
    rst = 1'b0;
    step("after_reset_redirect");

    // Random traffic with small register space to provoke matches
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      id_rs1_idx      = 5'($urandom_range(0, 3));
      id_rs2_idx      = 5'($urandom_range(0, 3));
      ex_rd_idx       = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_memtoreg     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ack         = 1'($urandom_range(0, 1));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_hazard_ctrl.md
RISCV_HAZARD_CTRL -- requirements
Module: riscv_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have inputs id_rs1_idx and id_rs2_idx, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have inputs id_use_rs1 and id_use_rs2, 1 bit each: the ID instruction reads that source.
REQ-005 SHALL have input ex_memtoreg, 1 bit, and input ex_rd_idx, 5 bits: load flag and destination of the instruction in EX.
REQ-006 SHALL have input ex_branch_taken, 1 bit: the EX-stage branch/jump resolved taken this cycle.
REQ-007 SHALL have inputs mem_req and mem_ack, 1 bit each: MEM-stage data-memory access request and completion.
REQ-008 SHALL have outputs pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, pc_redirect, 1 bit each.
REQ-009 SHALL have output mem_timeout, 1 bit: sticky data-memory watchdog error.
REQ-010 SHALL have outputs perf_stall_cnt and perf_flush_cnt, 32 bits each: performance counters.

Function
REQ-011 SHALL implement FSM states RUN, MEM_WAIT and REDIRECT, with registered state.
REQ-012 SHALL drive all stall/flush/redirect outputs combinationally from the current state and inputs (Mealy), giving zero-cycle latency to the pipeline registers.
REQ-013 SHALL detect load_use = ex_memtoreg & ex_rd_idx!=0 & ((id_use_rs1 & ex_rd_idx==id_rs1_idx) | (id_use_rs2 & ex_rd_idx==id_rs2_idx)).
REQ-014 SHALL define mem_wait = mem_req & !mem_ack.
REQ-015 SHALL apply this priority in RUN: mem_wait > ex_branch_taken > load_use > none.
REQ-016 In RUN with mem_wait, SHALL assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush, and go to MEM_WAIT.
REQ-017 In MEM_WAIT, SHALL keep the REQ-016 outputs asserted while mem_ack=0; on mem_ack=1 it SHALL deassert all outputs that cycle and return to RUN.
REQ-018 In RUN with ex_branch_taken and no mem_wait, SHALL assert pc_redirect, if_id_flush and id_ex_flush, and go to REDIRECT.
REQ-019 In REDIRECT, SHALL assert if_id_flush only (synchronous-imem bubble) and return to RUN unconditionally after 1 cycle; ex_branch_taken in REDIRECT SHALL be ignored.
REQ-020 A branch present during mem_wait SHALL NOT redirect, because EX is held; it SHALL be taken in the first RUN cycle after release.
REQ-021 In RUN with load_use only, SHALL assert pc_stall, if_id_stall and id_ex_flush for exactly that cycle and stay in RUN.
REQ-022 SHALL never assert a stage's stall and flush together; id_ex_stall=1 implies id_ex_flush=0.
REQ-023 SHALL run an 8-bit wait counter in MEM_WAIT, cleared on entry and saturating at 255; reaching 255 SHALL set mem_timeout, which stays set until rst.
REQ-024 The state-exit rules of REQ-017 SHALL be unaffected by mem_timeout.

Reset
REQ-025 While rst=1 at a clock edge, state SHALL become RUN, and the wait counter, mem_timeout, perf_stall_cnt and perf_flush_cnt SHALL become 0.
REQ-026 While rst=1, all stall/flush/redirect outputs SHALL be 0.
REQ-027 Reset mid-MEM_WAIT or mid-REDIRECT SHALL abort the state to RUN with no residual stall.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: perf_stall_cnt SHALL increment by 1 on every cycle with pc_stall=1.
REQ-029 Macro HAZARD_PERF_CNT_EN defined: perf_flush_cnt SHALL increment on every cycle with id_ex_flush=1 or if_id_flush=1.
REQ-030 Macro HAZARD_PERF_CNT_EN defined: both counters SHALL wrap at 2^32.
REQ-031 Macro HAZARD_PERF_CNT_EN undefined: both counter outputs SHALL be constant 0 and no counter flops SHALL be present.

Verification
REQ-032 Load-use: ex_memtoreg=1, ex_rd_idx=5, id_rs2_idx=5, id_use_rs2=1 -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle; state stays RUN. With ex_rd_idx=0 -> no stall.
REQ-033 Branch: ex_branch_taken=1 in RUN -> cycle0 pc_redirect=if_id_flush=id_ex_flush=1; cycle1 if_id_flush=1 only; cycle2 all 0.
REQ-034 Memory wait: mem_req=1, mem_ack=0 for 3 cycles then mem_ack=1 -> 3 cycles of all four stalls plus mem_wb_flush, 0 on the ack cycle, then RUN.
REQ-035 Simultaneous: mem_wait, ex_branch_taken and load_use together -> MEM_WAIT outputs only; pc_redirect fires in the first RUN cycle after ack.
REQ-036 Watchdog/reset: mem_ack held 0 for 300 cycles -> mem_timeout=1 from cycle 255; rst=1 mid-wait -> next cycle state RUN, outputs 0, mem_timeout=0.
REQ-037 Counters: with HAZARD_PERF_CNT_EN, the REQ-034 sequence -> perf_stall_cnt=3; the REQ-033 sequence -> perf_flush_cnt=2.
